// File: rtl/beam_thresh_pkg.sv
// Shared widths, broadcast index and sequencer state encoding for the beam threshold loader.
package beam_thresh_pkg;
  localparam int THRESH_BITS   = 18;
  localparam int BEAM_IDX_BITS = 8;
  localparam logic [BEAM_IDX_BITS-1:0] BEAM_IDX_BCAST = 8'hFF;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_INIT_UPD = 3'd1,
    ST_IDLE     = 3'd2,
    ST_UPD_WAIT = 3'd3,
    ST_UPD      = 3'd4
  } thresh_load_state_t;
endpackage

// File: rtl/dual_pueo_beam_thresh_loader.sv
// Threshold write sequencer for dual-beam DSP pairs: reset-time default load, per-beam/broadcast
// writes with 1-cycle ce latency, and a common update strobe placed at least one cycle after any ce.
module dual_pueo_beam_thresh_loader
  import beam_thresh_pkg::*;
#(
  parameter int                      NBEAMS         = 48,
  parameter logic [THRESH_BITS-1:0]  DEFAULT_THRESH = 18'h3FFFF,
  parameter string                   CLKTYPE        = "ACLK"
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [THRESH_BITS-1:0]   s_thresh_tdata,
  input  logic [BEAM_IDX_BITS-1:0] s_thresh_tuser,
  input  logic                     s_thresh_tvalid,
  output logic                     s_thresh_tready,
  input  logic                     update_req_i,
  output logic                     update_ack_o,
  output logic [THRESH_BITS-1:0]   thresh_o,
  output logic [NBEAMS-1:0]        thresh_ce_o,
  output logic                     update_o,
  output logic                     init_done_o,
  output logic                     err_o
);

  localparam logic [BEAM_IDX_BITS-1:0] LAST_BEAM = BEAM_IDX_BITS'(NBEAMS - 1);

  if ((NBEAMS % 2) != 0 || NBEAMS > 254 || CLKTYPE == "") begin : g_param_check
    $error("dual_pueo_beam_thresh_loader: NBEAMS must be even and <= 254, CLKTYPE non-empty");
  end

  thresh_load_state_t       state;
  logic [BEAM_IDX_BITS-1:0] beam_cnt;
  logic                     pending;
  logic                     wr_hs;

  assign wr_hs = s_thresh_tvalid && s_thresh_tready;

  function automatic logic [NBEAMS-1:0] beam_onehot(input logic [BEAM_IDX_BITS-1:0] idx);
    logic [NBEAMS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NBEAMS; i++) begin
      oh[i] = (idx == BEAM_IDX_BITS'(i));
    end
    return oh;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ST_INIT;
      beam_cnt        <= '0;
      pending         <= 1'b0;
      thresh_o        <= '0;
      thresh_ce_o     <= '0;
      update_o        <= 1'b0;
      update_ack_o    <= 1'b0;
      s_thresh_tready <= 1'b0;
      init_done_o     <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      thresh_ce_o  <= '0;
      update_o     <= 1'b0;
      update_ack_o <= 1'b0;

      case (state)
        ST_INIT: begin
          thresh_o    <= DEFAULT_THRESH;
          thresh_ce_o <= beam_onehot(beam_cnt);
          if (update_req_i) pending <= 1'b1;
          if (beam_cnt == LAST_BEAM) begin
            beam_cnt <= '0;
            state    <= ST_INIT_UPD;
          end else begin
            beam_cnt <= beam_cnt + 1'b1;
          end
        end

        // One idle cycle after the last ce before the strobe lands.
        ST_INIT_UPD: begin
          update_o <= 1'b1;
          if (update_req_i) pending <= 1'b1;
          state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (!s_thresh_tready) begin
            // Entry cycle after the reset commit: open the write port next cycle.
            s_thresh_tready <= 1'b1;
            init_done_o     <= 1'b1;
            if (update_req_i) pending <= 1'b1;
          end else begin
            if (wr_hs) begin
              if (s_thresh_tuser == BEAM_IDX_BCAST) begin
                thresh_o    <= s_thresh_tdata;
                thresh_ce_o <= '1;
              end else if (int'(s_thresh_tuser) < NBEAMS) begin
                thresh_o    <= s_thresh_tdata;
                thresh_ce_o <= beam_onehot(s_thresh_tuser);
              end else begin
                err_o <= 1'b1;
              end
            end
            if (update_req_i || pending) begin
              pending         <= 1'b0;
              s_thresh_tready <= 1'b0;
              state           <= ST_UPD_WAIT;
            end
          end
        end

        ST_UPD_WAIT: begin
          update_o     <= 1'b1;
          update_ack_o <= 1'b1;
          if (update_req_i) pending <= 1'b1;
          state <= ST_UPD;
        end

        ST_UPD: begin
          s_thresh_tready <= 1'b1;
          if (update_req_i) pending <= 1'b1;
          state <= ST_IDLE;
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_pueo_beam_thresh_loader.sv
// Directed bench for the beam threshold loader: reset load, writes, broadcast, error, pending updates, mid-INIT reset.
module tb_dual_pueo_beam_thresh_loader;
  localparam int          NB   = 48;
  localparam logic [17:0] DEFT = 18'h13880;

  logic              clk = 1'b0;
  logic              rst;
  logic [17:0]       tdata;
  logic [7:0]        tuser;
  logic              tvalid;
  logic              tready;
  logic              update_req;
  logic              update_ack;
  logic [17:0]       thresh;
  logic [NB-1:0]     ce;
  logic              update;
  logic              init_done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dual_pueo_beam_thresh_loader #(
    .NBEAMS(NB), .DEFAULT_THRESH(DEFT), .CLKTYPE("ACLK")
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_thresh_tdata(tdata), .s_thresh_tuser(tuser),
    .s_thresh_tvalid(tvalid), .s_thresh_tready(tready),
    .update_req_i(update_req), .update_ack_o(update_ack),
    .thresh_o(thresh), .thresh_ce_o(ce), .update_o(update),
    .init_done_o(init_done), .err_o(err)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] bit_of(input int k);
    logic [NB-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Entered in cycle 0 (first cycle with rst low); checks cycles 0..last_c and leaves at last_c+1.
  // with_reqs pulses update_req in cycles 3, 10 and 40, which must collapse into one update at 52.
  task automatic run_init(input bit with_reqs, input int last_c);
    logic [NB-1:0] exp_ce;
    for (int c = 0; c <= last_c; c++) begin
      update_req = with_reqs && (c == 3 || c == 10 || c == 40);
      exp_ce = (c >= 1 && c <= NB) ? bit_of(c - 1) : '0;
      chk_eq($sformatf("init_ce c%0d", c), 64'(ce), 64'(exp_ce));
      chk_eq($sformatf("init_thresh c%0d", c), 64'(thresh), (c == 0) ? 64'd0 : 64'(DEFT));
      chk_eq($sformatf("init_upd c%0d", c), 64'(update),
             64'((c == NB + 1) || (with_reqs && c == NB + 4)));
      chk_eq($sformatf("init_ack c%0d", c), 64'(update_ack), 64'(with_reqs && c == NB + 4));
      chk_eq($sformatf("init_rdy c%0d", c), 64'(tready),
             64'((c >= NB + 2) && !(with_reqs && (c == NB + 3 || c == NB + 4))));
      chk_eq($sformatf("init_done c%0d", c), 64'(init_done), 64'(c >= NB + 2));
      step();
    end
    update_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tuser = '0; tvalid = 1'b0; update_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk_eq("rst_err", 64'(err), 64'd0);

    // Reset load; now at cycle 50 with the write port open
    run_init(1'b0, 49);
    chk_eq("c50_rdy", 64'(tready), 64'd1);
    chk_eq("c50_upd", 64'(update), 64'd0);

    // Single write to beam 5, then an update request the following cycle
    tvalid = 1'b1; tuser = 8'd5; tdata = 18'h00100;
    step();
    tvalid = 1'b0;
    chk_eq("w5_thresh", 64'(thresh), 64'h00100);
    chk_eq("w5_ce", 64'(ce), 64'(bit_of(5)));
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    chk_eq("w5_wait_upd", 64'(update), 64'd0);
    chk_eq("w5_wait_rdy", 64'(tready), 64'd0);
    chk_eq("w5_wait_ce", 64'(ce), 64'd0);
    step();
    chk_eq("w5_upd", 64'(update), 64'd1);
    chk_eq("w5_ack", 64'(update_ack), 64'd1);
    step();
    chk_eq("w5_post_upd", 64'(update), 64'd0);
    chk_eq("w5_post_rdy", 64'(tready), 64'd1);

    // Broadcast write, then an out-of-range index that must be swallowed and flagged
    tvalid = 1'b1; tuser = 8'hFF; tdata = 18'h20000;
    step();
    chk_eq("bc_ce", 64'(ce), 64'(48'hFFFF_FFFF_FFFF));
    chk_eq("bc_thresh", 64'(thresh), 64'h20000);
    chk_eq("bc_err", 64'(err), 64'd0);
    tuser = 8'd60; tdata = 18'h00077;
    step();
    tvalid = 1'b0;
    chk_eq("oor_ce", 64'(ce), 64'd0);
    chk_eq("oor_err", 64'(err), 64'd1);
    chk_eq("oor_thresh_hold", 64'(thresh), 64'h20000);
    step();
    chk_eq("oor_err_sticky", 64'(err), 64'd1);
    chk_eq("oor_ce_idle", 64'(ce), 64'd0);

    // Write to beam 7 in the same cycle as an update request
    tvalid = 1'b1; tuser = 8'd7; tdata = 18'h00AAA; update_req = 1'b1;
    step();
    tvalid = 1'b0; update_req = 1'b0;
    chk_eq("w7_ce", 64'(ce), 64'(bit_of(7)));
    chk_eq("w7_thresh", 64'(thresh), 64'h00AAA);
    chk_eq("w7_rdy1", 64'(tready), 64'd0);
    chk_eq("w7_upd_early", 64'(update), 64'd0);
    step();
    chk_eq("w7_upd", 64'(update), 64'd1);
    chk_eq("w7_ack", 64'(update_ack), 64'd1);
    chk_eq("w7_rdy2", 64'(tready), 64'd0);
    chk_eq("w7_ce_clr", 64'(ce), 64'd0);
    step();
    chk_eq("w7_rdy3", 64'(tready), 64'd1);
    chk_eq("w7_err_still", 64'(err), 64'd1);

    // Full reset clears the sticky error; then reset again at INIT beam 20
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("rst2_err", 64'(err), 64'd0);
    chk_eq("rst2_done", 64'(init_done), 64'd0);
    run_init(1'b0, 20);
    chk_eq("mid_ce20", 64'(ce), 64'(bit_of(20)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("mid_rst_ce", 64'(ce), 64'd0);
    chk_eq("mid_rst_thresh", 64'(thresh), 64'd0);
    chk_eq("mid_rst_err", 64'(err), 64'd0);
    chk_eq("mid_rst_rdy", 64'(tready), 64'd0);

    // Restart from beam 0 with three requests during INIT
    run_init(1'b1, 55);
    chk_eq("pend_no_extra_upd", 64'(update), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
